// File: rtl/clklos_pkg.sv
// Shared definitions for the clock-loss monitor.
//   DefDivW     - default width of the detector-enable period divider
//   DefCntW     - default width of debounce thresholds and the event counter
//   los_state_e - debounce FSM states
package clklos_pkg;

  localparam int unsigned DefDivW = 16;
  localparam int unsigned DefCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StOk,
    StLoss
  } los_state_e;

endpackage

// File: rtl/clklos_strobe_gen.sv
// Detector-enable strobe generator.
// Counts 0..P-1 with P = max(div_val, 2) and emits det_en on the last count.
// The period is taken from div_val only at the start of each period (count 0),
// so a change mid-period takes effect after the next wrap.
//   ref_clk - clock, all logic on posedge
//   rst_n   - synchronous active-low reset
//   enable  - low holds the counter at 0 and det_en low
//   div_val - requested period in ref_clk cycles
//   det_en  - one-cycle strobe to the detector
module clklos_strobe_gen #(
  parameter int unsigned DIV_W = clklos_pkg::DefDivW
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  output logic             det_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] per_eff;

  always_comb begin
    // At count 0 a new period starts, so the live (clamped) div_val applies.
    per_eff = per_q;
    if (cnt_q == '0) begin
      per_eff = (div_val < DIV_W'(2)) ? DIV_W'(2) : div_val;
    end

    det_en = enable && (cnt_q == (per_eff - DIV_W'(1)));

    cnt_d = cnt_q;
    per_d = per_q;
    if (!enable) begin
      cnt_d = '0;
    end else begin
      per_d = per_eff;
      cnt_d = det_en ? '0 : (cnt_q + DIV_W'(1));
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      per_q <= DIV_W'(2);
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/clklos_mon.sv
// Clock-loss monitor: paces an external loss detector, debounces its flag and
// keeps a sticky interrupt plus a saturating count of loss declarations.
//   ref_clk   - clock, all logic on posedge
//   rst_n     - synchronous active-low reset
//   enable    - run; low forces IDLE and clears run state (los_int/los_cnt kept)
//   div_val   - det_en period in ref_clk cycles (min 2)
//   set_thr   - consecutive bad samples to declare loss (min 1)
//   clr_thr   - consecutive good samples to clear loss (min 1)
//   clk_loss  - detector flag, looked at only the cycle after det_en
//   int_clr   - pulse, clears los_int (a same-cycle declaration wins)
//   cnt_clr   - pulse, clears los_cnt (a same-cycle declaration leaves 1)
//   det_en    - one-cycle strobe to the detector
//   los_alarm - debounced loss state
//   los_int   - sticky loss interrupt
//   los_cnt   - saturating count of loss declarations
module clklos_mon
  import clklos_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] set_thr,
  input  logic [CNT_W-1:0] clr_thr,
  input  logic             clk_loss,
  input  logic             int_clr,
  input  logic             cnt_clr,
  output logic             det_en,
  output logic             los_alarm,
  output logic             los_int,
  output logic [CNT_W-1:0] los_cnt
);

  clklos_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_strobe (
    .ref_clk(ref_clk),
    .rst_n  (rst_n),
    .enable (enable),
    .div_val(div_val),
    .det_en (det_en)
  );

  los_state_e       state_q, state_d;
  logic             samp_q, samp_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             int_q, int_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W-1:0] t_set, t_clr;
  logic [CNT_W-1:0] bad_inc, good_inc, cnt_sat;
  logic             decl;

  // A zero threshold behaves as one.
  assign t_set = (set_thr == '0) ? CNT_W'(1) : set_thr;
  assign t_clr = (clr_thr == '0) ? CNT_W'(1) : clr_thr;

  // Runs stay below their threshold, so the increment cannot wrap.
  assign bad_inc  = bad_q + CNT_W'(1);
  assign good_inc = good_q + CNT_W'(1);
  assign cnt_sat  = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    good_d  = good_q;
    decl    = 1'b0;
    // The detector updates clk_loss on the strobe edge; look one cycle later.
    samp_d  = det_en;

    if (!enable) begin
      state_d = StIdle;
      bad_d   = '0;
      good_d  = '0;
      samp_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StArm;
        end
        StArm: begin
          // First sample reflects stale detector state; discard it.
          if (samp_q) begin
            state_d = StOk;
            bad_d   = '0;
            good_d  = '0;
          end
        end
        StOk: begin
          if (samp_q) begin
            if (!clk_loss) begin
              bad_d = '0;
            end else if (bad_inc >= t_set) begin
              state_d = StLoss;
              decl    = 1'b1;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              bad_d = bad_inc;
            end
          end
        end
        StLoss: begin
          if (samp_q) begin
            if (clk_loss) begin
              good_d = '0;
            end else if (good_inc >= t_clr) begin
              state_d = StOk;
              bad_d   = '0;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Declaration takes priority over the clear pulses.
    int_d = int_q;
    if (decl) begin
      int_d = 1'b1;
    end else if (int_clr) begin
      int_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (decl) begin
      cnt_d = cnt_clr ? CNT_W'(1) : cnt_sat;
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      samp_q  <= 1'b0;
      bad_q   <= '0;
      good_q  <= '0;
      int_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      int_q   <= int_d;
      cnt_q   <= cnt_d;
    end
  end

  assign los_alarm = (state_q == StLoss);
  assign los_int   = int_q;
  assign los_cnt   = cnt_q;

endmodule

// File: tb/tb_clklos_mon.sv
// Self-checking bench for clklos_mon: a per-cycle vector table followed by a
// saturation sequence, with expected outputs queued at drive time and compared
// one cycle later.
module tb_clklos_mon;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [15:0] dv;
    logic [7:0]  st;
    logic [7:0]  ct;
    logic        loss;
    logic        ic;
    logic        cc;
    logic        det;
    logic        al;
    logic        intr;
    logic [7:0]  cnt;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] div_val;
  logic [7:0]  set_thr;
  logic [7:0]  clr_thr;
  logic        clk_loss;
  logic        int_clr;
  logic        cnt_clr;
  logic        det_en;
  logic        los_alarm;
  logic        los_int;
  logic [7:0]  los_cnt;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  clklos_mon #(
    .DIV_W(16),
    .CNT_W(8)
  ) dut (
    .ref_clk  (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .div_val  (div_val),
    .set_thr  (set_thr),
    .clr_thr  (clr_thr),
    .clk_loss (clk_loss),
    .int_clr  (int_clr),
    .cnt_clr  (cnt_clr),
    .det_en   (det_en),
    .los_alarm(los_alarm),
    .los_int  (los_int),
    .los_cnt  (los_cnt)
  );

  function automatic vec_t mk(input logic r, input logic e, input int dv, input int st,
                              input int ct, input logic l, input logic ic, input logic cc,
                              input logic d, input logic a, input logic i, input int c,
                              input string tag);
    vec_t v;
    v.rst_n = r;  v.en = e;  v.dv = 16'(dv);  v.st = 8'(st);  v.ct = 8'(ct);
    v.loss = l;  v.ic = ic;  v.cc = cc;
    v.det = d;  v.al = a;  v.intr = i;  v.cnt = 8'(c);  v.tag = tag;
    return v;
  endfunction

  task automatic row(input logic r, input logic e, input int dv, input int st, input int ct,
                     input logic l, input logic ic, input logic cc,
                     input logic d, input logic a, input logic i, input int c,
                     input string tag);
    vecs.push_back(mk(r, e, dv, st, ct, l, ic, cc, d, a, i, c, tag));
  endtask

  // Drive on the falling edge, compare 1 time unit after the next rising edge.
  task automatic tick(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst_n    = v.rst_n;
    enable   = v.en;
    div_val  = v.dv;
    set_thr  = v.st;
    clr_thr  = v.ct;
    clk_loss = v.loss;
    int_clr  = v.ic;
    cnt_clr  = v.cc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (det_en !== e.det || los_alarm !== e.al || los_int !== e.intr || los_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s#%0d: got det=%b alarm=%b int=%b cnt=%0d, want det=%b alarm=%b int=%b cnt=%0d",
               e.tag, idx, det_en, los_alarm, los_int, los_cnt, e.det, e.al, e.intr, e.cnt);
    end
  endtask

  initial begin
    int c;
    int cprev;

    rst_n = 1'b0; enable = 1'b0; div_val = 16'd4; set_thr = 8'd3; clr_thr = 8'd2;
    clk_loss = 1'b0; int_clr = 1'b0; cnt_clr = 1'b0;

    //   rst en dv st ct loss ic cc | det al int cnt
    row(0, 0, 4, 3, 2, 0, 0, 0,  0, 0, 0, 0, "reset");
    row(0, 0, 4, 3, 2, 0, 0, 0,  0, 0, 0, 0, "reset");
    // Period 4 from enable; first sample (row 4) discarded even though bad.
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div4");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div4");
    row(1, 1, 4, 3, 2, 1, 0, 0,  1, 0, 0, 0, "div4_c3");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div4");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "arm_discard");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div4");
    row(1, 1, 4, 3, 2, 1, 0, 0,  1, 0, 0, 0, "div4_c7");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div4");
    row(1, 1, 4, 3, 2, 1, 0, 0,  0, 0, 0, 0, "bad1");
    // div_val drops to 1 mid-period: current period of 4 still completes.
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div_hold");
    row(1, 1, 1, 3, 2, 1, 0, 0,  1, 0, 0, 0, "div4_c11");
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 0, 0, 0, "wrap");
    row(1, 1, 1, 3, 2, 1, 0, 0,  1, 0, 0, 0, "bad2_div2");
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 0, 0, 0, "div2");
    row(1, 1, 1, 3, 2, 1, 0, 0,  1, 1, 1, 1, "bad3_loss");
    // Clear debounce: good, bad, good, good; odd rows are non-sample noise.
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 1, 1, 1, "loss");
    row(1, 1, 1, 3, 2, 0, 0, 0,  1, 1, 1, 1, "good1");
    row(1, 1, 1, 3, 2, 0, 0, 0,  0, 1, 1, 1, "loss");
    row(1, 1, 1, 3, 2, 1, 0, 0,  1, 1, 1, 1, "bad_reset");
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 1, 1, 1, "ignored");
    row(1, 1, 1, 3, 2, 0, 0, 0,  1, 1, 1, 1, "good1b");
    row(1, 1, 1, 3, 2, 1, 0, 0,  0, 1, 1, 1, "ignored");
    row(1, 1, 1, 3, 2, 0, 0, 0,  1, 0, 1, 1, "good2_clear");
    row(1, 1, 1, 3, 2, 0, 1, 0,  0, 0, 0, 1, "int_clr");
    // Declaration with coincident int_clr and cnt_clr.
    row(1, 1, 1, 1, 2, 1, 1, 1,  1, 1, 1, 1, "set_wins");
    row(1, 0, 1, 1, 2, 1, 0, 0,  0, 0, 1, 1, "en_drop");
    row(1, 0, 1, 1, 2, 1, 0, 0,  0, 0, 1, 1, "idle");
    row(1, 1, 1, 1, 2, 1, 0, 0,  1, 0, 1, 1, "reen");
    row(1, 1, 1, 1, 2, 1, 0, 0,  0, 0, 1, 1, "reen");
    row(1, 1, 1, 1, 2, 1, 0, 0,  1, 0, 1, 1, "reen_discard");
    row(1, 1, 1, 1, 2, 1, 0, 0,  0, 0, 1, 1, "ok");
    row(1, 1, 1, 1, 2, 1, 0, 0,  1, 1, 1, 2, "loss2");
    row(1, 1, 1, 3, 1, 0, 0, 0,  0, 1, 1, 2, "loss2");
    row(1, 1, 1, 3, 1, 0, 0, 0,  1, 0, 1, 2, "clr_thr1");
    row(1, 1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 2, "ok");
    row(1, 1, 1, 3, 1, 1, 0, 0,  1, 0, 1, 2, "bad1");
    row(1, 1, 1, 3, 1, 0, 0, 0,  0, 0, 1, 2, "ok");
    row(1, 1, 1, 3, 1, 1, 0, 0,  1, 0, 1, 2, "bad2");
    // Reset mid-debounce, then restart with div_val=0 (period 2).
    row(0, 1, 1, 3, 1, 1, 0, 0,  0, 0, 0, 0, "mid_reset");
    row(1, 1, 0, 3, 1, 1, 0, 0,  1, 0, 0, 0, "div0");
    row(1, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, "div0");
    row(1, 1, 0, 3, 1, 1, 0, 0,  1, 0, 0, 0, "post_rst_discard");
    row(1, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, "div0");
    row(1, 1, 0, 3, 1, 1, 0, 0,  1, 0, 0, 0, "post_rst_bad1");

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i], i);
    end

    // Saturation: repeated declare/clear cycles with thresholds of 1; the
    // last declaration also carries int_clr.
    cprev = 0;
    for (int k = 1; k <= 256; k++) begin
      c = (k > 255) ? 255 : k;
      tick(mk(1, 1, 0, 1, 1, 0, 1, 0,  0, 0, 0, cprev, "sat_iclr"), k);
      tick(mk(1, 1, 0, 1, 1, 1, (k == 256), 0,  1, 1, 1, c, "sat_decl"), k);
      tick(mk(1, 1, 0, 1, 1, 1, 0, 0,  0, 1, 1, c, "sat_loss"), k);
      tick(mk(1, 1, 0, 1, 1, 0, 0, 0,  1, 0, 1, c, "sat_clear"), k);
      cprev = c;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clklos_mon.md
CLKLOS_MON -- requirements
Module: clklos_mon

Interface
REQ-001 Parameter DIV_W, default 16, sets the width of the det_en period divider.
REQ-002 Parameter CNT_W, default 8, sets the width of the debounce thresholds and the event counter.
REQ-003 ref_clk  in  1  sole clock; all logic is on posedge.
REQ-004 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 enable  in  1  monitor run; low holds the block idle.
REQ-006 div_val  in  DIV_W  det_en period in ref_clk cycles.
REQ-007 set_thr  in  CNT_W  consecutive bad samples needed to declare loss.
REQ-008 clr_thr  in  CNT_W  consecutive good samples needed to clear loss.
REQ-009 clk_loss  in  1  registered loss flag returned from the detector.
REQ-010 int_clr  in  1  one-cycle pulse that clears los_int.
REQ-011 cnt_clr  in  1  one-cycle pulse that clears los_cnt.
REQ-012 det_en  out  1  one-cycle strobe to the detector.
REQ-013 los_alarm  out  1  debounced loss state.
REQ-014 los_int  out  1  sticky interrupt.
REQ-015 los_cnt  out  CNT_W  saturating count of loss declarations.

Function
REQ-016 Divider SHALL count 0..P-1, where P = max(div_val, 2); det_en SHALL be 1 exactly when the count equals P-1, then the count wraps to 0.
REQ-017 div_val SHALL be captured only at wrap; a change mid-period does not affect the current period.
REQ-018 While enable=0: divider held at 0, det_en=0, FSM in IDLE, run counters 0, los_alarm=0; los_int and los_cnt retained.
REQ-019 Sample point: the cycle after each det_en strobe (the detector updates clk_loss on the strobe edge); clk_loss SHALL be ignored at all other cycles.
REQ-020 FSM states: IDLE, ARM, OK, LOSS.
REQ-021 IDLE->ARM on enable=1.
REQ-022 ARM: first sample is discarded (stale detector state); -> OK at that sample point.
REQ-023 OK: bad sample increments bad_run; good sample zeroes bad_run; when bad_run reaches T_set = max(set_thr,1): -> LOSS, los_alarm=1 same edge, los_int set, los_cnt incremented (saturates at all-ones), runs zeroed.
REQ-024 LOSS: good sample increments good_run; bad sample zeroes good_run; when good_run reaches T_clr = max(clr_thr,1): -> OK, los_alarm=0, runs zeroed.
REQ-025 Thresholds are sampled at each sample point; a threshold lowered below the current run count triggers the transition at the next qualifying sample.
REQ-026 enable falling in any state SHALL force IDLE on the next edge, with no further transitions or counts.
REQ-027 int_clr coincident with a new loss declaration: set wins, los_int stays 1.
REQ-028 cnt_clr coincident with a loss declaration: los_cnt SHALL become 1.
REQ-029 los_cnt at all-ones SHALL remain all-ones on further declarations.

Reset
REQ-030 rst_n=0 SHALL force: det_en=0, los_alarm=0, los_int=0, los_cnt=0, divider=0, runs=0, FSM=IDLE.
REQ-031 Reset mid-period or mid-debounce SHALL discard all partial state; recovery restarts from ARM.

Structure
REQ-032 Package clklos_pkg SHALL hold the FSM state enum and default DIV_W/CNT_W constants.
REQ-033 The divider and strobe SHALL be a sub-module clklos_strobe_gen (ports: ref_clk, rst_n, enable, div_val, det_en); debounce/FSM/counters live in clklos_mon.

Verification
REQ-034 div_val=4, enable rises at cycle 0 -> det_en at cycles 3, 7, 11; div_val=0 or 1 -> period 2.
REQ-035 set_thr=3, clk_loss=1 at every sample after ARM -> los_alarm rises at the 3rd counted sample; los_int=1; los_cnt=1.
REQ-036 LOSS, clr_thr=2, samples good,bad,good,good -> alarm clears only on the 4th sample.
REQ-037 los_cnt=255 (CNT_W=8) plus a new declaration -> stays 255; int_clr coincident with the declaration -> los_int=1.
REQ-038 enable dropped during LOSS -> los_alarm=0 next cycle; re-enable -> first sample discarded, then OK.
REQ-039 rst_n pulsed low mid-debounce (bad_run=2, set_thr=3) -> all outputs 0; one later bad sample does not assert the alarm.
